// File: rtl/baudrx.sv
`default_nettype none
// ============================================================================
//  Module      : baudrx
//  Description : 8N1 serial receiver. Oversamples the rx line with a divisor
//                counter of BAUD clk cycles per bit, confirms the start bit at
//                half a bit time, samples each data bit and the stop bit once
//                per bit time, and emits a byte with a one-cycle rcv strobe or
//                a one-cycle ferr strobe when the stop bit is low.
//  Revision    : 1.0  initial release
// ============================================================================
module baudrx #(
    parameter int BAUD = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr
);

    localparam int             CW          = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CW-1:0]  c_CNT_MAX   = CW'(BAUD - 1);
    localparam logic [CW-1:0]  c_CNT_HALF  = CW'(BAUD / 2 - 1);
    localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
    localparam logic [2:0] c_ST_WAITHI = 3'd4;

    logic          r_sync1;
    logic          r_sync2;
    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitidx;

    logic          w_tick;
    logic          w_half;
    logic          w_rcv_set;
    logic          w_ferr_set;

    // Mid-bit markers: full bit period in DATA/STOP, half period in START
    assign w_tick = (r_cnt == c_CNT_MAX);
    assign w_half = (r_cnt == c_CNT_HALF);

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!r_sync2) w_next = c_ST_START;
            end
            c_ST_START: begin
                // A start bit that is already high again at half-bit is a glitch
                if (w_half) w_next = r_sync2 ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_tick && (r_bitidx == 3'd7)) w_next = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_tick) w_next = r_sync2 ? c_ST_IDLE : c_ST_WAITHI;
            end
            c_ST_WAITHI: begin
                // Break condition: wait for the line to return high before rearming
                if (r_sync2) w_next = c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // Output decode: stop-bit verdict, registered below into one-cycle pulses
    always_comb begin
        w_rcv_set  = 1'b0;
        w_ferr_set = 1'b0;
        if ((r_state == c_ST_STOP) && w_tick) begin
            w_rcv_set  = r_sync2;
            w_ferr_set = !r_sync2;
        end
    end

    // Divisor counter: restarts on every state change, wraps each bit time
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                     (r_state == c_ST_STOP)) begin
            r_cnt <= w_tick ? '0 : (r_cnt + c_CNT_ONE);
        end
    end

    // Data bit capture, LSB first into a right-shifting register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift  <= 8'h00;
            r_bitidx <= 3'd0;
        end else if ((r_state == c_ST_START) && (w_next == c_ST_DATA)) begin
            r_bitidx <= 3'd0;
        end else if ((r_state == c_ST_DATA) && w_tick) begin
            r_shift  <= {r_sync2, r_shift[7:1]};
            r_bitidx <= r_bitidx + 3'd1;
        end
    end

    // Registered outputs; data only moves on a correctly framed byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data <= 8'h00;
            rcv  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            rcv  <= w_rcv_set;
            ferr <= w_ferr_set;
            if (w_rcv_set) data <= r_shift;
        end
    end

endmodule
`default_nettype wire
